saph_pixel_writer: RTL and testbench

Pixel sink that terminates the rasterizer's pixel output handshake (`trig`/`ready`). It accepts one `pixel` per cycle, clips it against the configured framebuffer bounds, and converts the coordinates to a byte address. It then queues the write in a small FIFO and issues it to the framebuffer memory port over a valid/ready handshake. It sits between the rasterizer and the memory arbiter, and provides write/clip statistics and an idle flag for the command front-end.

---
 rtl/saph_pixel_writer.sv | 136 +++++++++++++
 tb/tb_saph_pixel_writer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/saph_pixel_writer.sv
// Pixel sink: clips rasterizer pixels against the framebuffer, converts (x,y) to a byte
// address and queues the write towards the memory port. in_pixel layout is {x, y, col}.
module saph_pixel_writer #(
    parameter int addr_width = 32,
    parameter int fifo_depth = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [addr_width-1:0] cfg_base,
    input  logic [15:0]           cfg_stride,
    input  logic [15:0]           cfg_width,
    input  logic [15:0]           cfg_height,
    input  logic                  in_trig,
    input  logic [63:0]           in_pixel,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [addr_width-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ready,
    output logic                  idle,
    output logic [31:0]           stat_written,
    output logic [31:0]           stat_clipped
);

    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic [31:0]        col;
    } pixel_t;

    localparam int PTR_W = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int CNT_W = $clog2(fifo_depth + 1);

    pixel_t                pix;
    logic                  accept;
    logic                  clip;
    logic                  push;
    logic                  pop;
    logic [31:0]           row_offset;
    logic [31:0]           pix_offset;
    logic [31:0]           byte_offset;
    logic [addr_width-1:0] pix_addr;
    logic [CNT_W:0]        occupancy;

    logic                  stage_valid_q, stage_valid_d;
    logic [addr_width-1:0] stage_addr_q, stage_addr_d;
    logic [31:0]           stage_data_q, stage_data_d;
    logic [addr_width-1:0] fifo_addr_q [fifo_depth];
    logic [addr_width-1:0] fifo_addr_d [fifo_depth];
    logic [31:0]           fifo_data_q [fifo_depth];
    logic [31:0]           fifo_data_d [fifo_depth];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [31:0]           written_q, written_d;
    logic [31:0]           clipped_q, clipped_d;

    assign pix = pixel_t'(in_pixel);

    // Signed coordinates: a set sign bit already clips, so the bound checks can be unsigned.
    assign clip = pix.x[15] | pix.y[15]
                | ($unsigned(pix.x) >= cfg_width)
                | ($unsigned(pix.y) >= cfg_height);

    assign row_offset  = {16'b0, pix.y} * {16'b0, cfg_stride};
    assign pix_offset  = row_offset + {16'b0, pix.x};
    assign byte_offset = pix_offset << 2;
    assign pix_addr    = cfg_base + addr_width'(byte_offset);

    assign occupancy = {1'b0, count_q} + (CNT_W+1)'(stage_valid_q);
    assign in_ready  = occupancy < (CNT_W+1)'(fifo_depth);
    assign accept    = in_trig && in_ready;
    assign mem_we    = count_q != '0;
    assign push      = stage_valid_q;
    assign pop       = mem_we && mem_ready;
    assign idle      = !stage_valid_q && (count_q == '0);

    // The head is gated so the port reads zero while empty, even over unreset storage.
    assign mem_addr     = mem_we ? fifo_addr_q[rd_ptr_q] : '0;
    assign mem_wdata    = mem_we ? fifo_data_q[rd_ptr_q] : '0;
    assign stat_written = written_q;
    assign stat_clipped = clipped_q;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
        stage_addr_d = stage_addr_q;
        stage_data_d = stage_data_q;
        fifo_addr_d  = fifo_addr_q;
        fifo_data_d  = fifo_data_q;

        stage_valid_d = accept && !clip;
        if (accept && !clip) begin
            stage_addr_d = pix_addr;
            stage_data_d = pix.col;
        end

        if (push) begin
            fifo_addr_d[wr_ptr_q] = stage_addr_q;
            fifo_data_d[wr_ptr_q] = stage_data_q;
        end

        wr_ptr_d  = wr_ptr_q + PTR_W'(push);
        rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
        written_d = written_q + 32'(pop);
        clipped_d = clipped_q + 32'(accept && clip);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_valid_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            written_q     <= '0;
            clipped_q     <= '0;
        end else begin
            stage_valid_q <= stage_valid_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            written_q     <= written_d;
            clipped_q     <= clipped_d;
        end
    end

    // NOTE: payload storage is not reset; the valid/count flops alone decide what is live.
    always_ff @(posedge clk) begin
        stage_addr_q <= stage_addr_d;
        stage_data_q <= stage_data_d;
        fifo_addr_q  <= fifo_addr_d;
        fifo_data_q  <= fifo_data_d;
    end

endmodule

// File: tb/tb_saph_pixel_writer.sv
// Bench for saph_pixel_writer: queue-based reference model checked every cycle, plus
// hand-computed addresses and counts for the directed scenarios.
module tb_saph_pixel_writer;

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic [31:0]        col;
  } pixel_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] cfg_base;
  logic [15:0] cfg_stride, cfg_width, cfg_height;
  logic        in_trig;
  pixel_t      in_pixel;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic        idle;
  logic [31:0] stat_written, stat_clipped;

  saph_pixel_writer #(.addr_width(32), .fifo_depth(4)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_base(cfg_base), .cfg_stride(cfg_stride),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .in_trig(in_trig), .in_pixel(in_pixel),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .idle(idle), .stat_written(stat_written), .stat_clipped(stat_clipped)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference model: pending writes as a plain queue plus the one-pixel stage.
  wr_t         m_q[$];
  bit          m_stage_v = 1'b0;
  wr_t         m_stage;
  logic [31:0] m_written = '0;
  logic [31:0] m_clipped = '0;
  logic [31:0] obs_addr[$];
  logic        last_we = 1'b0;
  logic [31:0] last_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_clip(input pixel_t p);
    return (int'(p.x) < 0) || (int'(p.y) < 0) ||
           (int'(p.x) >= int'(cfg_width)) || (int'(p.y) >= int'(cfg_height));
  endfunction

  function automatic logic [31:0] m_addr(input pixel_t p);
    longint unsigned off;
    off = ((longint'(p.y) * longint'(cfg_stride) + longint'(p.x)) * 4) % 64'h1_0000_0000;
    return 32'((longint'(cfg_base) + off) % 64'h1_0000_0000);
  endfunction

  always @(posedge clk) begin
    bit acc, popd;
    acc  = in_trig && ((m_q.size() + int'(m_stage_v)) < 4);
    popd = (m_q.size() > 0) && mem_ready;
    if (rst_n && last_we && mem_ready) obs_addr.push_back(last_addr);
    if (!rst_n) begin
      m_q.delete();
      m_stage_v = 1'b0;
      m_written = '0;
      m_clipped = '0;
    end else begin
      if (popd) begin
        void'(m_q.pop_front());
        m_written = m_written + 1;
      end
      if (m_stage_v) m_q.push_back(m_stage);
      m_stage_v = 1'b0;
      if (acc) begin
        if (m_clip(in_pixel)) m_clipped = m_clipped + 1;
        else begin
          m_stage_v    = 1'b1;
          m_stage.addr = m_addr(in_pixel);
          m_stage.data = in_pixel.col;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] exp_addr, exp_data;
    last_we   = mem_we;
    last_addr = mem_addr;
    if (cmp_en) begin
      exp_addr = '0;
      exp_data = '0;
      if (m_q.size() > 0) begin
        exp_addr = m_q[0].addr;
        exp_data = m_q[0].data;
      end
      check("in_ready", in_ready, 32'((m_q.size() + int'(m_stage_v)) < 4));
      check("mem_we", mem_we, 32'(m_q.size() != 0));
      check("mem_addr", mem_addr, exp_addr);
      check("mem_wdata", mem_wdata, exp_data);
      check("idle", idle, 32'(!m_stage_v && m_q.size() == 0));
      check("stat_written", stat_written, m_written);
      check("stat_clipped", stat_clipped, m_clipped);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_pix(input int x, input int y, input logic [31:0] col);
    in_pixel.x   = 16'(x);
    in_pixel.y   = 16'(y);
    in_pixel.col = col;
  endtask

  task automatic wait_idle(input string name, input int limit);
    bit done;
    done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      if (idle) done = 1'b1;
      else tick();
    end
    check(name, 32'(idle), 32'd1);
  endtask

  // Single pixel through the pipe with mem_ready high; pins latency and address by hand.
  task automatic write_one(input string name, input int x, input int y,
                           input logic [31:0] col, input logic [31:0] exp_addr);
    set_pix(x, y, col);
    in_trig = 1'b1;
    tick();
    in_trig = 1'b0;
    check({name, "_we_early"}, 32'(mem_we), 32'd0);
    tick();
    check({name, "_we"}, 32'(mem_we), 32'd1);
    check({name, "_addr"}, mem_addr, exp_addr);
    check({name, "_data"}, mem_wdata, col);
    tick();
    check({name, "_idle"}, 32'(idle), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int    acc;
    int    we_seen;
    logic  rdy;
    int    w, h;

    rst_n      = 1'b0;
    in_trig    = 1'b0;
    mem_ready  = 1'b0;
    cfg_base   = 32'h1000;
    cfg_stride = 16'd320;
    cfg_width  = 16'd320;
    cfg_height = 16'd240;
    set_pix(0, 0, 32'h0);
    tick();
    tick();
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_written", stat_written, 32'd0);

    // Basic write: (2*320+5)*4 + 0x1000 = 0x1A14.
    mem_ready = 1'b1;
    write_one("basic", 5, 2, 32'hAABBCCDD, 32'h1A14);
    check("basic_written", stat_written, 32'd1);

    // Clipping on every edge of the window.
    set_pix(-1, 0, 32'h1);   in_trig = 1'b1; tick();
    set_pix(320, 0, 32'h2);  tick();
    set_pix(0, 240, 32'h3);  tick();
    set_pix(0, -5, 32'h4);   tick();
    in_trig = 1'b0;
    tick();
    check("clip_count", stat_clipped, 32'd4);
    check("clip_idle", 32'(idle), 32'd1);
    check("clip_written", stat_written, 32'd1);

    // Last visible pixel: (239*320+319)*4 + 0x1000 = 0x4BFFC.
    write_one("corner", 319, 239, 32'h12345678, 32'h0004_BFFC);

    // Backpressure: only four pixels fit while the memory stalls.
    obs_addr.delete();
    mem_ready = 1'b0;
    acc = 0;
    set_pix(0, 0, 32'h100);
    in_trig = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rdy = in_ready;
      tick();
      if (rdy) begin
        acc++;
        set_pix(acc, 0, 32'h100 + 32'(acc));
      end
    end
    check("bp_accepted", 32'(acc), 32'd4);
    check("bp_ready_low", 32'(in_ready), 32'd0);
    check("bp_addr_hold", mem_addr, 32'h1000);
    mem_ready = 1'b1;
    for (int i = 0; i < 60 && acc < 8; i++) begin
      rdy = in_ready;
      tick();
      if (rdy) begin
        acc++;
        set_pix(acc, 0, 32'h100 + 32'(acc));
      end
    end
    in_trig = 1'b0;
    wait_idle("bp_drain", 40);
    check("bp_total", 32'(acc), 32'd8);
    check("bp_written", stat_written, 32'd10);
    check("bp_obs_count", 32'(obs_addr.size()), 32'd8);
    for (int i = 0; i < 8 && i < obs_addr.size(); i++)
      check("bp_order", obs_addr[i], 32'h1000 + 32'(4 * i));

    // Reset with three writes pending behind a stalled memory.
    mem_ready = 1'b0;
    in_trig   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_pix(i, 1, 32'hBEEF0000 + 32'(i));
      tick();
    end
    in_trig = 1'b0;
    tick();
    tick();
    check("rstmid_pending", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rstmid_we", 32'(mem_we), 32'd0);
    check("rstmid_idle", 32'(idle), 32'd1);
    check("rstmid_written", stat_written, 32'd0);
    check("rstmid_clipped", stat_clipped, 32'd0);
    check("rstmid_ready", 32'(in_ready), 32'd1);
    mem_ready = 1'b1;
    we_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (mem_we) we_seen++;
    end
    check("rstmid_no_stale", 32'(we_seen), 32'd0);

    // Address wrap: 0xFFFFFFF0 + 8*4 wraps to 0x10.
    cfg_base = 32'hFFFF_FFF0;
    write_one("wrap", 8, 0, 32'hCAFEF00D, 32'h0000_0010);

    // Randomized phases; configuration changes only while idle.
    for (int k = 0; k < 4; k++) begin
      in_trig = 1'b0;
      mem_ready = 1'b1;
      wait_idle("rand_idle", 40);
      w = $urandom_range(1, 64);
      h = $urandom_range(1, 64);
      cfg_base   = $urandom;
      cfg_width  = 16'(w);
      cfg_height = 16'(h);
      cfg_stride = (k == 3) ? 16'hFFFF : 16'($urandom_range(w, 2000));
      for (int c = 0; c < 300; c++) begin
        if (k == 0) begin
          // Saturated input with mem_ready toggling: full occupancy with push and pop together.
          in_trig   = 1'b1;
          mem_ready = c[0];
          set_pix($urandom_range(0, w - 1), $urandom_range(0, h - 1), $urandom);
        end else begin
          in_trig   = ($urandom_range(0, 3) != 0);
          mem_ready = ($urandom_range(0, 2) != 0);
          set_pix(int'($urandom_range(0, w + 8)) - 4, int'($urandom_range(0, h + 8)) - 4, $urandom);
        end
        tick();
      end
    end
    in_trig   = 1'b0;
    mem_ready = 1'b1;
    wait_idle("final_idle", 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
